spi_shift_engine: RTL

SPI master serialiser that sits between the TX and RX FIFO instances of the spi_master core. It pops words from the TX FIFO, whose data output is combinational show-ahead, and shifts them out MSB-first on MOSI. It simultaneously samples MISO and pushes each received word into the RX FIFO. It generates SCLK from a parameterised divider, supports all four CPOL/CPHA modes, and drives a single chip-select.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 60 ++++++
 rtl/spi_shift_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding and sizing constants for the SPI shift engine and its
// SCLK generator.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      STORE = 3'd3,
      NEXT  = 3'd4
   } spi_state_e;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_CLK_DIV = 4;

   // Edge counter must hold 2*WIDTH toggles.
   function automatic int unsigned bit_cnt_w(input int unsigned width);
      return $clog2(2 * width) + 1;
   endfunction

   localparam int unsigned BIT_CNT_W = bit_cnt_w(DEF_WIDTH);

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while run is high and flags
// leading/trailing/last edges of a 2*WIDTH-toggle frame.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV,
   parameter int unsigned CNT_W   = BIT_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic cpol,
   output logic sclk,
   output logic lead_pulse,
   output logic trail_pulse,
   output logic last_edge
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] edge_q, edge_d;
   logic             sclk_q, sclk_d;
   logic             edge_now;

   always_comb begin
      edge_now    = run && (div_q == DIV_W'(CLK_DIV - 1));
      lead_pulse  = edge_now && !edge_q[0];
      trail_pulse = edge_now && edge_q[0];
      last_edge   = edge_now && (edge_q == CNT_W'(2 * WIDTH - 1));
      div_d       = '0;
      edge_d      = '0;
      sclk_d      = cpol;
      if (run) begin
         sclk_d = sclk_q;
         div_d  = edge_now ? '0 : div_q + 1'b1;
         edge_d = edge_q;
         if (edge_now) begin
            sclk_d = ~sclk_q;
            edge_d = last_edge ? '0 : edge_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q  <= '0;
         edge_q <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         edge_q <= edge_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master serialiser: pops TX FIFO words, shifts them MSB-first on MOSI,
// assembles MISO into RX words and pushes them to the RX FIFO.
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [WIDTH-1:0] tx_dout,
   input  logic             tx_empty,
   output logic             tx_re,
   output logic [WIDTH-1:0] rx_din,
   input  logic             rx_full,
   output logic             rx_we,
   output logic             sclk,
   output logic             mosi,
   input  logic             miso,
   output logic             cs_n,
   output logic             busy
);

   spi_state_e       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] rx_din_q, rx_din_d;
   logic             cpol_q, cpol_d, cpha_q, cpha_d;
   logic             mosi_q, mosi_d, cs_n_q, cs_n_d;
   logic             tx_re_q, tx_re_d, rx_we_q, rx_we_d, busy_q, busy_d;
   logic             sclk_pol, lead_pulse, trail_pulse, last_edge;
   logic             sample, drive;

   // In IDLE sclk tracks the live cpol input; once a frame starts it uses the latched copy.
   assign sclk_pol = (state_q == IDLE) ? cpol : cpol_q;

   spi_sclk_gen #(
      .WIDTH   (WIDTH),
      .CLK_DIV (CLK_DIV),
      .CNT_W   (bit_cnt_w(WIDTH))
   ) u_sclk_gen (
      .clk         (clk),
      .rst         (rst),
      .run         (state_q == SHIFT),
      .cpol        (sclk_pol),
      .sclk        (sclk),
      .lead_pulse  (lead_pulse),
      .trail_pulse (trail_pulse),
      .last_edge   (last_edge)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      rx_din_d = rx_din_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      mosi_d   = mosi_q;
      cs_n_d   = cs_n_q;
      tx_re_d  = 1'b0;
      rx_we_d  = 1'b0;
      sample   = cpha_q ? trail_pulse : lead_pulse;
      drive    = cpha_q ? lead_pulse : (trail_pulse && !last_edge);
      unique case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            if (en && !tx_empty) begin
               state_d = LOAD;
               tx_re_d = 1'b1;
               cpol_d  = cpol;
               cpha_d  = cpha;
            end
         end
         LOAD: begin
            shift_d = tx_dout;
            cs_n_d  = 1'b0;
            if (!cpha_q) mosi_d = tx_dout[WIDTH-1];
            state_d = SHIFT;
         end
         SHIFT: begin
            if (sample) shift_d = {shift_q[WIDTH-2:0], miso};
            if (drive) mosi_d = shift_q[WIDTH-1];
            if (last_edge) state_d = STORE;
         end
         STORE: begin
            if (!rx_full) begin
               rx_din_d = shift_q;
               rx_we_d  = 1'b1;
               state_d  = NEXT;
            end
         end
         NEXT: begin
            if (en && !tx_empty) begin
               state_d = LOAD;
               tx_re_d = 1'b1;
            end else begin
               state_d = IDLE;
               cs_n_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         rx_din_q <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         tx_re_q  <= 1'b0;
         rx_we_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         rx_din_q <= rx_din_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         mosi_q   <= mosi_d;
         cs_n_q   <= cs_n_d;
         tx_re_q  <= tx_re_d;
         rx_we_q  <= rx_we_d;
         busy_q   <= busy_d;
      end
   end

   assign tx_re  = tx_re_q;
   assign rx_we  = rx_we_q;
   assign rx_din = rx_din_q;
   assign mosi   = mosi_q;
   assign cs_n   = cs_n_q;
   assign busy   = busy_q;

endmodule
